// File: rtl/ife_pkg.sv
// Shared types for the IFE-to-core block dispatch path.
package ife_pkg;

  localparam int ID_W = 8;

  typedef logic [3:0][31:0] block_data_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    block_data_t     data;
    logic            par;
    logic            pair;
  } disp_entry_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Two-write / two-read circular buffer of dispatch entries.
// Exposes head, head+1 and occupancy.
module dispatch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = ife_pkg::disp_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             wr_cnt_i,
  input  entry_t                 wr0_i,
  input  entry_t                 wr1_i,
  input  logic [1:0]             rd_cnt_i,
  output entry_t                 head_o,
  output entry_t                 head1_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp1, rp1;
  logic [CW-1:0] cnt_q, cnt_d;

  assign wp1 = wp_q + AW'(1);
  assign rp1 = rp_q + AW'(1);

  always_comb begin
    wp_d  = wp_q + AW'(wr_cnt_i);
    rp_d  = rp_q + AW'(rd_cnt_i);
    cnt_d = cnt_q + CW'(wr_cnt_i) - CW'(rd_cnt_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; count gates every use of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_cnt_i != 2'd0) mem_q[wp_q] <= wr0_i;
      if (wr_cnt_i == 2'd2) mem_q[wp1]  <= wr1_i;
    end
  end

  assign head_o  = mem_q[rp_q];
  assign head1_o = mem_q[rp1];
  assign count_o = cnt_q;

endmodule

// File: rtl/block_dispatcher.sv
// Buffers IFE blocks and issues them round-robin to free nebula cores.
// DISPATCH_STATS_EN adds per-core saturating issue counters (issue_count).
module block_dispatcher #(
  parameter int NUM_CORES  = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = ife_pkg::ID_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             serial_valid,
  input  logic [ID_W-1:0]                  serial_block_id,
  input  logic [3:0][31:0]                 serial_block_data,
  input  logic [1:0]                       par_valid,
  input  logic [ID_W-1:0]                  par_block_id,
  input  logic [1:0][3:0][31:0]            par_block_data,
  output logic                             in_ready,
  input  logic [NUM_CORES-1:0]             core_busy,
  output logic [NUM_CORES-1:0]             block_valid,
  output logic [NUM_CORES-1:0][3:0][31:0]  block_data,
  output logic [NUM_CORES-1:0][ID_W-1:0]   block_id,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             drop_err
`ifdef DISPATCH_STATS_EN
  ,
  output logic [NUM_CORES-1:0][15:0]       issue_count
`endif
);

  import ife_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(NUM_CORES);

  typedef struct packed {
    logic [ID_W-1:0] id;
    block_data_t     data;
    logic            par;
    logic            pair;
  } entry_t;

  entry_t     wr0, wr1, head, head1;
  logic [1:0] wr_cnt, rd_cnt;
  logic       any_in, drop;
  logic       head_v;
  logic       unused_ok;

  logic [NUM_CORES-1:0]            elig, issue;
  logic [NUM_CORES-1:0]            valid_q;
  logic [NUM_CORES-1:0][3:0][31:0] data_q;
  logic [NUM_CORES-1:0][ID_W-1:0]  id_q;
  logic                            drop_q;
  logic [PW-1:0]                   rr_q, rr_d;
  logic [PW-1:0]                   c0, c1;
  logic                            f0, f1;
  logic [PW:0]                     idx;

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] c);
    return (c == PW'(NUM_CORES - 1)) ? '0 : c + PW'(1);
  endfunction

  dispatch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_cnt_i (wr_cnt),
    .wr0_i    (wr0),
    .wr1_i    (wr1),
    .rd_cnt_i (rd_cnt),
    .head_o   (head),
    .head1_o  (head1),
    .count_o  (fifo_count)
  );

  assign any_in   = serial_valid | (|par_valid);
  assign in_ready = fifo_count <= CW'(FIFO_DEPTH - 2);
  assign head_v   = fifo_count != '0;

  always_comb begin
    wr0    = '0;
    wr1    = '0;
    wr_cnt = 2'd0;
    drop   = 1'b0;
    priority case (1'b1)
      !in_ready: drop = any_in;
      serial_valid: begin
        wr0    = '{id: serial_block_id, data: serial_block_data,
                   par: 1'b0, pair: 1'b0};
        wr_cnt = 2'd1;
        drop   = |par_valid;
      end
      par_valid[0]: begin
        wr0    = '{id: par_block_id, data: par_block_data[0],
                   par: 1'b1, pair: par_valid[1]};
        wr1    = '{id: par_block_id, data: par_block_data[1],
                   par: 1'b1, pair: 1'b0};
        wr_cnt = par_valid[1] ? 2'd2 : 2'd1;
      end
      par_valid[1]: begin
        wr0    = '{id: par_block_id, data: par_block_data[1],
                   par: 1'b1, pair: 1'b0};
        wr_cnt = 2'd1;
      end
      default: ;
    endcase
  end

  // A core that was just issued to may not have raised busy yet.
  assign elig = ~core_busy & ~valid_q;

  always_comb begin
    f0  = 1'b0;
    f1  = 1'b0;
    c0  = '0;
    c1  = '0;
    idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = {1'b0, rr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_CORES))
        idx = idx - (PW+1)'(NUM_CORES);
      if (elig[idx[PW-1:0]]) begin
        if (!f0) begin
          f0 = 1'b1;
          c0 = idx[PW-1:0];
        end else if (!f1) begin
          f1 = 1'b1;
          c1 = idx[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    issue  = '0;
    rd_cnt = 2'd0;
    rr_d   = rr_q;
    if (head_v) begin
      if (head.pair) begin
        if (f1) begin
          issue[c0] = 1'b1;
          issue[c1] = 1'b1;
          rd_cnt    = 2'd2;
          rr_d      = rr_next(c1);
        end
      end else if (f0) begin
        issue[c0] = 1'b1;
        rd_cnt    = 2'd1;
        rr_d      = rr_next(c0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= '0;
      valid_q <= '0;
      data_q  <= '0;
      id_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      valid_q <= issue;
      drop_q  <= drop_q | drop;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (issue[c]) begin
          if (head.pair && PW'(c) == c1) begin
            data_q[c] <= head1.data;
            id_q[c]   <= head1.id;
          end else begin
            data_q[c] <= head.data;
            id_q[c]   <= head.id;
          end
        end
      end
    end
  end

  assign block_valid = valid_q;
  assign block_data  = data_q;
  assign block_id    = id_q;
  assign drop_err    = drop_q;
  assign unused_ok   = ^{head.par, head1.par, head1.pair};

`ifdef DISPATCH_STATS_EN
  logic [NUM_CORES-1:0][15:0] stat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (issue[c] && stat_q[c] != 16'hFFFF)
          stat_q[c] <= stat_q[c] + 16'd1;
      end
    end
  end

  assign issue_count = stat_q;
`endif

endmodule
